inst_fetch_ctrl: RTL and testbench

//  Instruction-memory responder for the 16-bit pipeline. It accepts the fetch address and

---
 rtl/inst_fetch_ctrl_pkg.sv | 38 +++
 rtl/inst_fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_ctrl_pkg
// Description : Shared types, constants and helpers for the instruction
//               fetch controller of the 16-bit pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_ctrl_pkg;

    // Bus types
    typedef logic [15:0] inst_addr_t;   // PC / instruction address
    typedef logic [15:0] inst_t;        // instruction word
    typedef logic [17:0] sram_addr_t;   // external SRAM address {bank, pc}
    typedef logic [2:0]  wait_cnt_t;    // wait-state counter

    // Instruction inserted whenever no fetched word is available
    localparam inst_t c_nop_inst = 16'h0800;

    // Generic enable levels
    localparam logic c_enable  = 1'b1;
    localparam logic c_disable = 1'b0;

    // SRAM strobes are active low
    localparam logic c_chip_enable  = 1'b0;
    localparam logic c_chip_disable = 1'b1;

    // Fetch FSM encodings
    localparam logic [0:0] c_fetch_idle   = 1'b0;
    localparam logic [0:0] c_fetch_access = 1'b1;

    // Build the full SRAM address from the bank bits and the PC
    function automatic sram_addr_t make_sram_addr(input logic [1:0] bank,
                                                  input inst_addr_t pc);
        return {bank, pc};
    endfunction

endpackage : inst_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_ctrl
// Description : Instruction-memory responder. Runs a multi-cycle read on the
//               external instruction SRAM for the address presented by the
//               PC register, stalls the PC while the read is in flight,
//               returns the word to IF/ID and yields the shared SRAM bus to
//               the MEM stage when it is not busy.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,      // read wait states, 0..7
    parameter logic [1:0]  BANK        = 2'b00   // upper SRAM address bits
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active low
    input  logic [15:0] pc_i,
    input  logic        ce_i,
    input  logic        flush_i,
    input  logic        mem_req_i,
    output logic        mem_grant_o,
    output logic        stallreq_o,
    output logic [15:0] inst_o,
    output logic        inst_valid_o,
    output logic [17:0] sram_addr_o,
    input  logic [15:0] sram_data_i,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o
);

    // Terminal count of the wait counter; the counter is 3 bits wide so the
    // wait-state count is limited to 0..7.
    localparam wait_cnt_t c_wait_max = wait_cnt_t'(WAIT_CYCLES);

    logic [0:0] state;
    logic [0:0] next_state;
    wait_cnt_t  cnt;
    logic       last_beat;      // final ACCESS cycle, data is captured at its edge
    logic       start_fetch;    // IDLE cycle that launches a new read

    // The read is complete once the counter has reached the wait-state count.
    assign last_beat   = (state == c_fetch_access) && (cnt == c_wait_max);

    // MEM has priority over a new fetch, and a flush suppresses any launch.
    assign start_fetch = (state == c_fetch_idle) && !mem_req_i && !flush_i && ce_i;

    // The controller never writes to instruction memory.
    assign sram_we_n_o = c_chip_disable;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= c_fetch_idle;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: launch from IDLE, leave ACCESS on completion or flush
    always_comb begin
        next_state = state;
        case (state)
            c_fetch_idle: begin
                if (start_fetch) begin
                    next_state = c_fetch_access;
                end
            end
            c_fetch_access: begin
                if (flush_i || last_beat) begin
                    next_state = c_fetch_idle;
                end
            end
            default: begin
                next_state = c_fetch_idle;
            end
        endcase
    end

    // Output logic: bus grant and stall request are combinational so the PC
    // and MEM stage react within the current cycle.
    always_comb begin
        mem_grant_o = c_disable;
        stallreq_o  = c_disable;
        case (state)
            c_fetch_idle: begin
                // In IDLE a pending fetch always holds the PC: it either
                // launches now or waits behind MEM / a flush.
                mem_grant_o = mem_req_i;
                stallreq_o  = ce_i;
            end
            c_fetch_access: begin
                // The bus stays with the fetch until it completes; the PC is
                // released in the capture cycle so it advances at that edge.
                mem_grant_o = c_disable;
                stallreq_o  = !last_beat;
            end
            default: begin
                mem_grant_o = c_disable;
                stallreq_o  = c_disable;
            end
        endcase
    end

    // Datapath: SRAM address/strobes, wait counter and instruction capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            inst_o       <= c_nop_inst;
            inst_valid_o <= c_disable;
            sram_addr_o  <= '0;
            sram_ce_n_o  <= c_chip_disable;
            sram_oe_n_o  <= c_chip_disable;
        end else begin
            case (state)
                c_fetch_idle: begin
                    cnt          <= '0;
                    inst_valid_o <= c_disable;
                    if (start_fetch) begin
                        // Latch the address; it stays fixed for the whole read
                        // regardless of later PC changes. inst_o keeps the
                        // previous word until the new one arrives.
                        sram_addr_o <= make_sram_addr(BANK, pc_i);
                        sram_ce_n_o <= c_chip_enable;
                        sram_oe_n_o <= c_chip_enable;
                    end else begin
                        // No launch this cycle (idle, MEM owns the bus, or a
                        // flush): present a bubble to IF/ID.
                        inst_o      <= c_nop_inst;
                        sram_ce_n_o <= c_chip_disable;
                        sram_oe_n_o <= c_chip_disable;
                    end
                end
                c_fetch_access: begin
                    if (flush_i) begin
                        // A flush wins over a completion in the same cycle.
                        cnt          <= '0;
                        inst_o       <= c_nop_inst;
                        inst_valid_o <= c_disable;
                        sram_ce_n_o  <= c_chip_disable;
                        sram_oe_n_o  <= c_chip_disable;
                    end else if (last_beat) begin
                        cnt          <= '0;
                        inst_o       <= sram_data_i;
                        inst_valid_o <= c_enable;
                        sram_ce_n_o  <= c_chip_disable;
                        sram_oe_n_o  <= c_chip_disable;
                    end else begin
                        // Counter stops at the terminal count, so it never wraps.
                        cnt          <= cnt + wait_cnt_t'(1);
                        inst_valid_o <= c_disable;
                    end
                end
                default: begin
                    cnt          <= '0;
                    inst_valid_o <= c_disable;
                    sram_ce_n_o  <= c_chip_disable;
                    sram_oe_n_o  <= c_chip_disable;
                end
            endcase
        end
    end

endmodule : inst_fetch_ctrl
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_ctrl
// Description : Directed, self-checking bench for inst_fetch_ctrl. One
//               instance uses one wait state and bank 0, a second uses zero
//               wait states and bank 2. The SRAM is modelled as a function of
//               the address; expected words are queued when a fetch is
//               launched and popped when inst_valid_o pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: WAIT_CYCLES=1, BANK=0
    logic [15:0] pc, inst, sram_data;
    logic        ce, flush, mem_req, grant, stall, valid;
    logic [17:0] addr;
    logic        ce_n, oe_n, we_n;

    // Instance Z: WAIT_CYCLES=0, BANK=2
    logic [15:0] pc_z, inst_z, sram_data_z;
    logic        ce_z, flush_z, mem_req_z, grant_z, stall_z, valid_z;
    logic [17:0] addr_z;
    logic        ce_n_z, oe_n_z, we_n_z;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sb[$];

    // Content of the instruction memory at a given PC
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h4C05;
    endfunction

    // SRAM only drives meaningful data while both strobes are active
    assign sram_data   = (!ce_n   && !oe_n)   ? mem_word(addr[15:0])   : 16'hDEAD;
    assign sram_data_z = (!ce_n_z && !oe_n_z) ? mem_word(addr_z[15:0]) : 16'hDEAD;

    inst_fetch_ctrl #(.WAIT_CYCLES(1), .BANK(2'b00)) dut (
        .clk(clk), .rst(rst_n), .pc_i(pc), .ce_i(ce), .flush_i(flush),
        .mem_req_i(mem_req), .mem_grant_o(grant), .stallreq_o(stall),
        .inst_o(inst), .inst_valid_o(valid), .sram_addr_o(addr),
        .sram_data_i(sram_data), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n),
        .sram_we_n_o(we_n)
    );

    inst_fetch_ctrl #(.WAIT_CYCLES(0), .BANK(2'b10)) dut_z (
        .clk(clk), .rst(rst_n), .pc_i(pc_z), .ce_i(ce_z), .flush_i(flush_z),
        .mem_req_i(mem_req_z), .mem_grant_o(grant_z), .stallreq_o(stall_z),
        .inst_o(inst_z), .inst_valid_o(valid_z), .sram_addr_o(addr_z),
        .sram_data_i(sram_data_z), .sram_ce_n_o(ce_n_z), .sram_oe_n_o(oe_n_z),
        .sram_we_n_o(we_n_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard: every valid pulse of instance A must match the oldest
    // outstanding expected word
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            n_checks++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_valid observed inst=%0h expected no pulse", inst);
            end
            if (sb.size() > 0) begin
                logic [15:0] e;
                e = sb.pop_front();
                n_checks++;
                assert (inst === e) else begin
                    n_fail++;
                    $error("FAIL sb_inst observed=%0h expected=%0h", inst, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        pc = '0; ce = 1'b0; flush = 1'b0; mem_req = 1'b0;
        pc_z = '0; ce_z = 1'b0; flush_z = 1'b0; mem_req_z = 1'b0;

        // ---- reset values ----
        #12;
        chk("rst_inst",  inst, 16'h0800);
        chk("rst_valid", valid, 0);
        chk("rst_ce_n",  ce_n, 1);
        chk("rst_oe_n",  oe_n, 1);
        chk("rst_we_n",  we_n, 1);
        chk("rst_addr",  addr, 0);
        chk("rst_stall", stall, 0);
        next_cycle();
        rst_n = 1'b1;

        // ---- single fetch, pc=4 ----
        pc = 16'h0004; ce = 1'b1;
        sb.push_back(16'h4C01);
        mid();
        chk("f1_c0_stall", stall, 1);
        chk("f1_c0_grant", grant, 0);
        chk("f1_c0_ce_n",  ce_n, 1);
        next_cycle();
        pc = 16'h0009; ce = 1'b0;
        mid();
        chk("f1_c1_stall", stall, 1);
        chk("f1_c1_addr",  addr, 18'h00004);
        chk("f1_c1_ce_n",  ce_n, 0);
        chk("f1_c1_oe_n",  oe_n, 0);
        chk("f1_c1_we_n",  we_n, 1);
        next_cycle();
        mid();
        chk("f1_c2_stall", stall, 0);
        chk("f1_c2_addr",  addr, 18'h00004);
        chk("f1_c2_valid", valid, 0);
        next_cycle();
        mid();
        chk("f1_c3_valid", valid, 1);
        chk("f1_c3_inst",  inst, 16'h4C01);
        next_cycle();
        mid();
        chk("f1_c4_inst_nop", inst, 16'h0800);
        chk("f1_c4_valid",    valid, 0);
        next_cycle();

        // ---- back-to-back fetches at pc 0,1,2 ----
        for (int i = 0; i < 3; i++) begin
            pc = 16'(i); ce = 1'b1;
            sb.push_back(mem_word(16'(i)));
            mid();
            chk("b2b_c0_stall", stall, 1);
            if (i > 0) begin
                chk("b2b_c0_valid", valid, 1);
                chk("b2b_c0_inst",  inst, mem_word(16'(i - 1)));
            end
            next_cycle();
            mid();
            chk("b2b_c1_valid", valid, 0);
            chk("b2b_c1_stall", stall, 1);
            next_cycle();
            mid();
            chk("b2b_c2_valid", valid, 0);
            chk("b2b_c2_stall", stall, 0);
            next_cycle();
        end

        // ---- flush in last ACCESS cycle (fetch launched in pc=2 valid cycle) ----
        pc = 16'h0007; ce = 1'b1;
        mid();
        chk("fl_c0_valid", valid, 1);
        chk("fl_c0_inst",  inst, mem_word(16'h0002));
        next_cycle();
        ce = 1'b0;
        mid();
        chk("fl_c1_inst_hold", inst, mem_word(16'h0002));
        chk("fl_c1_stall",     stall, 1);
        next_cycle();
        flush = 1'b1;
        mid();
        chk("fl_c2_stall", stall, 0);
        next_cycle();
        flush = 1'b0;
        mid();
        chk("fl_c3_valid", valid, 0);
        chk("fl_c3_inst",  inst, 16'h0800);
        chk("fl_c3_ce_n",  ce_n, 1);
        chk("fl_c3_stall", stall, 0);
        next_cycle();

        // ---- flush in IDLE suppresses launch ----
        pc = 16'h0003; ce = 1'b1; flush = 1'b1;
        mid();
        chk("fli_stall", stall, 1);
        next_cycle();
        flush = 1'b0; ce = 1'b0;
        mid();
        chk("fli_ce_n",  ce_n, 1);
        chk("fli_stall", stall, 0);
        next_cycle();

        // ---- MEM request vs fetch ----
        mem_req = 1'b1; ce = 1'b1; pc = 16'h0002;
        mid();
        chk("mem_c0_grant", grant, 1);
        chk("mem_c0_stall", stall, 1);
        chk("mem_c0_ce_n",  ce_n, 1);
        next_cycle();
        mem_req = 1'b0;
        sb.push_back(mem_word(16'h0002));
        mid();
        chk("mem_c1_grant", grant, 0);
        chk("mem_c1_ce_n",  ce_n, 1);
        next_cycle();
        mem_req = 1'b1; ce = 1'b0;
        mid();
        chk("mem_c2_grant", grant, 0);
        chk("mem_c2_ce_n",  ce_n, 0);
        next_cycle();
        mid();
        chk("mem_c3_grant", grant, 0);
        next_cycle();
        mid();
        chk("mem_c4_grant", grant, 1);
        chk("mem_c4_valid", valid, 1);
        next_cycle();
        mem_req = 1'b0;

        // ---- asynchronous reset in the middle of an access ----
        pc = 16'h0005; ce = 1'b1;
        sb.push_back(mem_word(16'h0005));
        next_cycle();
        ce = 1'b0;
        next_cycle();
        next_cycle();
        pc = 16'h0006; ce = 1'b1;
        mid();
        chk("ar_valid_pre", valid, 1);
        next_cycle();
        ce = 1'b0;
        mid();
        chk("ar_inst_pre", inst, mem_word(16'h0005));
        chk("ar_ce_n_pre", ce_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ce_n",  ce_n, 1);
        chk("ar_oe_n",  oe_n, 1);
        chk("ar_inst",  inst, 16'h0800);
        chk("ar_valid", valid, 0);
        chk("ar_addr",  addr, 0);
        next_cycle();
        rst_n = 1'b1;
        mid();
        chk("ar_post_ce_n",  ce_n, 1);
        chk("ar_post_valid", valid, 0);
        chk("ar_post_stall", stall, 0);
        next_cycle();
        mid();
        chk("ar_post2_valid", valid, 0);
        next_cycle();

        // ---- zero wait states, bank 2 ----
        pc_z = 16'h1234; ce_z = 1'b1;
        mid();
        chk("z_c0_stall", stall_z, 1);
        next_cycle();
        pc_z = 16'h0010;
        mid();
        chk("z_c1_addr",  addr_z, 18'h21234);
        chk("z_c1_stall", stall_z, 0);
        chk("z_c1_ce_n",  ce_n_z, 0);
        next_cycle();
        mid();
        chk("z_c2_valid", valid_z, 1);
        chk("z_c2_inst",  inst_z, mem_word(16'h1234));
        chk("z_c2_stall", stall_z, 1);
        next_cycle();
        ce_z = 1'b0;
        mid();
        chk("z_c3_addr",  addr_z, 18'h20010);
        chk("z_c3_stall", stall_z, 0);
        chk("z_c3_valid", valid_z, 0);
        next_cycle();
        mid();
        chk("z_c4_valid", valid_z, 1);
        chk("z_c4_inst",  inst_z, mem_word(16'h0010));
        next_cycle();
        mid();
        chk("z_c5_valid", valid_z, 0);
        chk("z_c5_inst",  inst_z, 16'h0800);

        // ---- every expected word was delivered ----
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch_ctrl
`default_nettype wire
